// File: rtl/gmm_subtract_fg_classify_pipe_pkg.sv
// Shared constants and types for the GMM foreground classifier.
// Field widths follow the existing colour/variance layout of the subtractor:
// 8-bit colour channels, 16-bit cluster variances, up to 3 clusters per pixel.
package gmm_subtract_fg_classify_pipe_pkg;

    localparam int PIX_W      = 8;
    localparam int VAR_W      = 16;
    localparam int TH_W       = 8;
    localparam int N_CH       = 3;
    localparam int N_CLUST    = 3;
    localparam int SQ_W       = 2 * PIX_W;
    localparam int D2_W       = 18;
    localparam int PROD_W     = VAR_W + TH_W;
    localparam int CNT_W_DEF  = 22;
    localparam int VAR_SH_DEF = 4;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] fg_count;
        logic                 valid;
    } fg_stat_t;

    // A cluster takes part in the match only if it exists (k < n) and is one
    // of the background clusters (k <= B). B beyond n-1 is therefore harmless.
    function automatic logic is_cand(input int k, input logic [1:0] n, input logic [1:0] b);
        return (k < int'(n)) && (k <= int'(b));
    endfunction

endpackage

// File: rtl/gmm_subtract_fg_classify_pipe_sq_dist.sv
// Combinational 3-channel squared colour distance.
// Ports:
//   pix_i   : pixel colour, one byte per channel
//   color_i : cluster mean, one byte per channel
//   d2_o    : sum of squared per-channel differences (max 3*255^2, fits 18b)
module gmm_subtract_fg_classify_pipe_sq_dist
    import gmm_subtract_fg_classify_pipe_pkg::*;
(
    input  logic [N_CH-1:0][PIX_W-1:0] pix_i,
    input  logic [N_CH-1:0][PIX_W-1:0] color_i,
    output logic [D2_W-1:0]            d2_o
);

    logic [PIX_W-1:0] ad;
    logic [SQ_W-1:0]  sq;

    // |d| squared equals d*d for the signed 9-bit difference, without
    // carrying a sign bit through the multiplier.
    always_comb begin
        d2_o = '0;
        ad   = '0;
        sq   = '0;
        for (int c = 0; c < N_CH; c++) begin
            ad   = (pix_i[c] >= color_i[c]) ? (pix_i[c] - color_i[c]) : (color_i[c] - pix_i[c]);
            sq   = SQ_W'(ad) * SQ_W'(ad);
            d2_o = d2_o + D2_W'(sq);
        end
    end

endmodule

// File: rtl/gmm_subtract_fg_classify_pipe.sv
// Foreground classifier: matches each pixel against the background clusters
// selected by B-calc and emits a 1-bit foreground flag, plus a per-frame
// foreground pixel count.
// Pipeline: S1 distance, S2 threshold compare, S3 output register. All stages
// share one enable, so a downstream stall freezes the whole pipe.
// Ports:
//   clk, rst                       : clock, async active-high reset
//   var_th                         : match threshold, Q4.4
//   snk_valid/snk_ready            : input handshake
//   snk_pix, snk_mem_color,
//   snk_mem_var, snk_n, snk_B,
//   snk_eop                        : per-pixel beat from B-calc
//   src_valid/src_ready            : output handshake
//   src_fg, src_eop                : foreground flag and end-of-frame
//   stat_valid, stat_fg_count      : one-cycle pulse with completed frame count
module gmm_subtract_fg_classify_pipe
    import gmm_subtract_fg_classify_pipe_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int VAR_SH = VAR_SH_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [TH_W-1:0]                      var_th,
    input  logic                                 snk_valid,
    output logic                                 snk_ready,
    input  logic [N_CH-1:0][PIX_W-1:0]           snk_pix,
    input  logic [N_CLUST-1:0][N_CH-1:0][PIX_W-1:0] snk_mem_color,
    input  logic [N_CLUST-1:0][VAR_W-1:0]        snk_mem_var,
    input  logic [1:0]                           snk_n,
    input  logic [1:0]                           snk_B,
    input  logic                                 snk_eop,
    input  logic                                 src_ready,
    output logic                                 src_valid,
    output logic                                 src_fg,
    output logic                                 src_eop,
    output logic                                 stat_valid,
    output logic [CNT_W-1:0]                     stat_fg_count
);

    logic en;

    logic [N_CLUST-1:0][D2_W-1:0]  d2_s1_d;
    logic [N_CLUST-1:0][D2_W-1:0]  s1_d2_q;
    logic [N_CLUST-1:0][VAR_W-1:0] s1_var_q;
    logic [1:0]                    s1_n_q, s1_b_q;
    logic                          s1_valid_q, s1_eop_q;

    logic [N_CLUST-1:0]            hit;
    logic [PROD_W-1:0]             lhs, rhs;
    logic                          s2_fg_d;
    logic                          s2_valid_q, s2_fg_q, s2_eop_q;

    logic                          src_valid_q, src_fg_q, src_eop_q;

    logic [CNT_W-1:0]              cnt_q, cnt_d, cnt_next;
    logic [CNT_W-1:0]              stat_cnt_q, stat_cnt_d;
    logic                          stat_valid_q, stat_valid_d;

    assign en        = src_ready | ~src_valid_q;
    assign snk_ready = en;

    for (genvar k = 0; k < N_CLUST; k++) begin : g_dist
        gmm_subtract_fg_classify_pipe_sq_dist u_dist (
            .pix_i   (snk_pix),
            .color_i (snk_mem_color[k]),
            .d2_o    (d2_s1_d[k])
        );
    end

    // Strict compare: equality is not a match, and var or var_th of zero
    // makes the right side zero so nothing can match that cluster.
    always_comb begin
        hit = '0;
        lhs = '0;
        rhs = '0;
        for (int k = 0; k < N_CLUST; k++) begin
            lhs    = PROD_W'(s1_d2_q[k]) << VAR_SH;
            rhs    = PROD_W'(s1_var_q[k]) * PROD_W'(var_th);
            hit[k] = (lhs < rhs) && is_cand(k, s1_n_q, s1_b_q);
        end
        s2_fg_d = ~|hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_d2_q     <= '0;
            s1_var_q    <= '0;
            s1_n_q      <= '0;
            s1_b_q      <= '0;
            s1_eop_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_fg_q     <= 1'b0;
            s2_eop_q    <= 1'b0;
            src_valid_q <= 1'b0;
            src_fg_q    <= 1'b0;
            src_eop_q   <= 1'b0;
        end else if (en) begin
            s1_valid_q  <= snk_valid;
            s1_d2_q     <= d2_s1_d;
            s1_var_q    <= snk_mem_var;
            s1_n_q      <= snk_n;
            s1_b_q      <= snk_B;
            s1_eop_q    <= snk_eop;
            s2_valid_q  <= s1_valid_q;
            s2_fg_q     <= s2_fg_d;
            s2_eop_q    <= s1_eop_q;
            src_valid_q <= s2_valid_q;
            src_fg_q    <= s2_fg_q;
            src_eop_q   <= s2_eop_q;
        end
    end

    // Frame count advances only on an accepted output beat; the eop beat's
    // own flag is included in the reported total.
    always_comb begin
        cnt_next     = (&cnt_q) ? cnt_q : (cnt_q + CNT_W'(src_fg_q));
        cnt_d        = cnt_q;
        stat_cnt_d   = stat_cnt_q;
        stat_valid_d = 1'b0;
        if (src_valid_q && src_ready) begin
            if (src_eop_q) begin
                stat_cnt_d   = cnt_next;
                stat_valid_d = 1'b1;
                cnt_d        = '0;
            end else begin
                cnt_d        = cnt_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            stat_cnt_q   <= '0;
            stat_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            stat_cnt_q   <= stat_cnt_d;
            stat_valid_q <= stat_valid_d;
        end
    end

    assign src_valid     = src_valid_q;
    assign src_fg        = src_fg_q;
    assign src_eop       = src_eop_q;
    assign stat_valid    = stat_valid_q;
    assign stat_fg_count = stat_cnt_q;

endmodule

// File: tb/tb_gmm_subtract_fg_classify_pipe.sv
// Directed bench for the GMM foreground classifier pipeline.
module tb_gmm_subtract_fg_classify_pipe;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [7:0]              var_th;
    logic                    snk_valid;
    logic                    snk_ready;
    logic [2:0][7:0]         pix;
    logic [2:0][2:0][7:0]    col;
    logic [2:0][15:0]        vr;
    logic [1:0]              n;
    logic [1:0]              b;
    logic                    eop;
    logic                    src_ready;
    logic                    src_valid;
    logic                    src_fg;
    logic                    src_eop;
    logic                    stat_valid;
    logic [21:0]             stat_fg_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_stat   = 0;
    logic [21:0] last_stat = '0;

    always #5 clk = ~clk;

    gmm_subtract_fg_classify_pipe dut (
        .clk           (clk),
        .rst           (rst),
        .var_th        (var_th),
        .snk_valid     (snk_valid),
        .snk_ready     (snk_ready),
        .snk_pix       (pix),
        .snk_mem_color (col),
        .snk_mem_var   (vr),
        .snk_n         (n),
        .snk_B         (b),
        .snk_eop       (eop),
        .src_ready     (src_ready),
        .src_valid     (src_valid),
        .src_fg        (src_fg),
        .src_eop       (src_eop),
        .stat_valid    (stat_valid),
        .stat_fg_count (stat_fg_count)
    );

    always @(negedge clk) begin
        if (stat_valid) begin
            n_stat    <= n_stat + 1;
            last_stat <= stat_fg_count;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pixel (100,100,100); every cluster mean at (0,0,0) is far away.
    task automatic beat_default();
        pix = {8'd100, 8'd100, 8'd100};
        col = '0;
        vr  = {16'd16, 16'd16, 16'd16};
        n   = 2'd1;
        b   = 2'd0;
        eop = 1'b0;
    endtask

    task automatic set_fg(input logic fg, input logic e);
        beat_default();
        if (!fg) col[0] = pix;
        eop = e;
    endtask

    // Single beat into an empty pipe: visible exactly three edges after accept.
    task automatic run_single(input string tag, input logic exp_fg);
        snk_valid = 1'b1;
        chk({tag, "_rdy"}, snk_ready, 1);
        tick();
        snk_valid = 1'b0;
        tick();
        chk({tag, "_early"}, src_valid, 0);
        tick();
        chk({tag, "_vld"}, src_valid, 1);
        chk({tag, "_fg"}, src_fg, exp_fg);
        tick();
    endtask

    task automatic feed(input logic fg, input logic e);
        set_fg(fg, e);
        snk_valid = 1'b1;
        tick();
        snk_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic efg [4];
        logic eeo [4];
        logic fr [10];
        int   idx;
        int   base;

        efg = '{1'b1, 1'b0, 1'b1, 1'b0};
        eeo = '{1'b0, 1'b0, 1'b1, 1'b1};
        fr  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        rst       = 1'b1;
        src_ready = 1'b1;
        snk_valid = 1'b0;
        var_th    = 8'h30;
        beat_default();
        repeat (2) tick();
        chk("rst_src_valid", src_valid, 0);
        chk("rst_src_fg", src_fg, 0);
        chk("rst_src_eop", src_eop, 0);
        chk("rst_stat_valid", stat_valid, 0);
        chk("rst_stat_count", stat_fg_count, 0);
        chk("rst_snk_ready", snk_ready, 1);
        rst = 1'b0;
        tick();

        // d2=0 < 16*48
        beat_default(); col[0] = pix;
        run_single("t1_exact", 0);
        // d2=100 -> 1600 >= 768; then 1600 < 200*48
        beat_default(); pix[0] = 8'd110; col[0] = {8'd100, 8'd100, 8'd100};
        run_single("t2_far", 1);
        vr[0] = 16'd200;
        run_single("t2_widevar", 0);
        // cluster1 matches but B=0 excludes it
        beat_default(); n = 2'd3; b = 2'd0; col[1] = pix;
        run_single("t3_b0", 1);
        b = 2'd1;
        run_single("t3_b1", 0);
        // d2=48 -> 768 == 768 is not a match; d2=41 -> 656 < 768
        beat_default(); col[0] = {8'd96, 8'd96, 8'd96};
        run_single("eq_boundary", 1);
        col[0] = {8'd104, 8'd104, 8'd103};
        run_single("below_boundary", 0);
        beat_default(); n = 2'd0; col[0] = pix;
        run_single("n_zero", 1);
        beat_default(); col[0] = pix; vr[0] = 16'd0;
        run_single("var_zero", 1);
        beat_default(); col[0] = pix; var_th = 8'h00;
        run_single("th_zero", 1);
        var_th = 8'h30;
        beat_default(); n = 2'd1; b = 2'd2; col[1] = pix;
        run_single("b_clamp", 1);
        // d2=195075 -> 3121200; 65535*255 matches, 65535*47=3080145 does not
        beat_default(); pix = {8'd255, 8'd255, 8'd255}; vr[0] = 16'hFFFF; var_th = 8'hFF;
        run_single("max_match", 0);
        var_th = 8'h2F;
        run_single("max_nomatch", 1);
        var_th = 8'h30;

        // Stall with three beats in the pipe and a fourth waiting at the input.
        src_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_fg(efg[i], eeo[i]);
            snk_valid = 1'b1;
            tick();
        end
        chk("stall_fill", src_valid, 1);
        src_ready = 1'b0;
        set_fg(efg[3], eeo[3]);
        snk_valid = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_snk_ready", snk_ready, 0);
            chk("stall_src_valid", src_valid, 1);
            chk("stall_src_fg", src_fg, efg[0]);
            chk("stall_src_eop", src_eop, eeo[0]);
            tick();
        end
        src_ready = 1'b1;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            if (src_valid) begin
                if (idx < 4) begin
                    chk("drain_fg", src_fg, efg[idx]);
                    chk("drain_eop", src_eop, eeo[idx]);
                end
                idx++;
            end
            tick();
            if (c == 0) snk_valid = 1'b0;
        end
        chk("drain_count", idx, 4);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        base = n_stat;

        // 10-pixel frame with 4 foreground pixels and one input bubble.
        for (int i = 0; i < 10; i++) begin
            if (i == 5) tick();
            feed(fr[i], i == 9);
        end
        repeat (5) tick();
        chk("f1_pulses", n_stat - base, 1);
        chk("f1_count", last_stat, 4);
        chk("f1_hold", stat_fg_count, 4);
        feed(1'b0, 1'b0);
        feed(1'b0, 1'b0);
        feed(1'b0, 1'b1);
        repeat (5) tick();
        chk("f2_pulses", n_stat - base, 2);
        chk("f2_count", last_stat, 0);

        // Reset with beats in flight and a partially counted frame.
        base = n_stat;
        for (int i = 0; i < 4; i++) feed(1'b1, 1'b0);
        chk("pre_rst_valid", src_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", src_valid, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_no_pulse", n_stat - base, 0);
        chk("post_rst_stat_count", stat_fg_count, 0);
        feed(1'b1, 1'b0);
        feed(1'b0, 1'b0);
        feed(1'b1, 1'b1);
        repeat (5) tick();
        chk("f3_pulses", n_stat - base, 1);
        chk("f3_count", last_stat, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
